// File: rtl/mfp_7seg_scan_if.sv
// Display-side signal bundle for the eight-digit 7-segment scanner:
// the digit, enable and decimal-point inputs, and the registered cathode/anode drive.
interface mfp_7seg_scan_if;
  logic [31:0] IO_7SEG;
  logic [7:0]  IO_7SEGE;
  logic [7:0]  IO_7SEGDP;
  logic [7:0]  AN;
  logic [6:0]  CA;
  logic        DP;
  logic        FRAME_TICK;

  modport master (
    output IO_7SEG, IO_7SEGE, IO_7SEGDP,
    input  AN, CA, DP, FRAME_TICK
  );

  modport slave (
    input  IO_7SEG, IO_7SEGE, IO_7SEGDP,
    output AN, CA, DP, FRAME_TICK
  );
endinterface

// File: rtl/mfp_7seg_scan.sv
// Eight-digit multiplexed 7-segment scanner with per-slot blanking and a
// frame-synchronous shadow copy of the inputs so a frame never tears.
module mfp_7seg_scan #(
  parameter int unsigned DIV_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input logic           HCLK,
  input logic           HRESETn,
  mfp_7seg_scan_if.slave bus
);

  typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

  localparam logic [15:0] CNT_LAST  = 16'(DIV_CYCLES - 1);
  localparam logic [15:0] CNT_BLANK = 16'(BLANK_CYCLES);

  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  phase_t      phase_reg, phase_next;
  logic [31:0] val_reg, val_next;
  logic [7:0]  en_reg, en_next;
  logic [7:0]  dpm_reg, dpm_next;
  logic [7:0]  an_reg, an_next;
  logic [6:0]  ca_reg, ca_next;
  logic        dp_reg, dp_next;
  logic        tick_reg, tick_next;

  logic        wrap;
  logic        capture;
  logic        lit;
  logic [3:0]  nibble;
  logic [7:0]  an_dec;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One-hot-low anode pattern for the current digit index.
  for (genvar gi = 0; gi < 8; gi++) begin : g_an
    assign an_dec[gi] = (idx_reg != 3'(gi));
  end

  always_comb begin
    wrap       = (cnt_reg == CNT_LAST);
    capture    = wrap && (idx_reg == 3'd7);
    cnt_next   = wrap ? 16'd0 : cnt_reg + 16'd1;
    idx_next   = wrap ? idx_reg + 3'd1 : idx_reg;
    // Phase is tracked one step ahead so phase_reg always matches cnt_reg.
    phase_next = (cnt_next < CNT_BLANK) ? PH_BLANK : PH_SHOW;
    val_next   = val_reg;
    en_next    = en_reg;
    dpm_next   = dpm_reg;
    if (capture) begin
      val_next = bus.IO_7SEG;
      en_next  = bus.IO_7SEGE;
      dpm_next = bus.IO_7SEGDP;
    end

    nibble    = val_reg[{idx_reg, 2'b00} +: 4];
    lit       = (phase_reg == PH_SHOW) && en_reg[idx_reg];
    an_next   = 8'hFF;
    ca_next   = 7'h7F;
    dp_next   = 1'b1;
    tick_next = capture;
    if (lit) begin
      an_next = an_dec;
      ca_next = ~seg(nibble);
      dp_next = ~dpm_reg[idx_reg];
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt_reg   <= 16'd0;
      idx_reg   <= 3'd0;
      phase_reg <= PH_BLANK;
      val_reg   <= 32'd0;
      en_reg    <= 8'd0;
      dpm_reg   <= 8'd0;
      an_reg    <= 8'hFF;
      ca_reg    <= 7'h7F;
      dp_reg    <= 1'b1;
      tick_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      phase_reg <= phase_next;
      val_reg   <= val_next;
      en_reg    <= en_next;
      dpm_reg   <= dpm_next;
      an_reg    <= an_next;
      ca_reg    <= ca_next;
      dp_reg    <= dp_next;
      tick_reg  <= tick_next;
    end
  end

  assign bus.AN         = an_reg;
  assign bus.CA         = ca_reg;
  assign bus.DP         = dp_reg;
  assign bus.FRAME_TICK = tick_reg;

endmodule

// File: tb/tb_mfp_7seg_scan.sv
// Directed bench for mfp_7seg_scan with DIV_CYCLES=8, BLANK_CYCLES=2 (64-cycle frames);
// outputs are sampled on the falling edge, k counts rising edges since the last reset release.
module tb_mfp_7seg_scan;
  logic HCLK = 1'b0;
  logic HRESETn;
  int   n_vec = 0;
  int   n_miss = 0;

  mfp_7seg_scan_if bus();

  mfp_7seg_scan #(.DIV_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  // Active-low cathode codes ~seg(n), worked out by hand.
  logic [6:0] ca_exp [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 32'(bus.AN), 32'hFF);
    chk({tag, "_ca"}, 32'(bus.CA), 32'h7F);
    chk({tag, "_dp"}, 32'(bus.DP), 32'h1);
  endtask

  // Starting at k=0, walks one whole frame checking it stays dark and ticks only at k=64.
  task automatic dark_frame(input string tag);
    for (int k = 1; k <= 64; k++) begin
      wait_edges(1);
      chk({tag, "_an"}, 32'(bus.AN), 32'hFF);
      chk({tag, "_ca"}, 32'(bus.CA), 32'h7F);
      chk({tag, "_tick"}, 32'(bus.FRAME_TICK), (k == 64) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] last_an;
    logic [7:0] an_e;
    int ff_run, ticks, last_tick, q;

    HRESETn       = 1'b0;
    bus.IO_7SEG   = 32'h76543210;
    bus.IO_7SEGE  = 8'hFF;
    bus.IO_7SEGDP = 8'h00;
    wait_edges(2);
    chk_dark("rst");
    chk("rst_tick", 32'(bus.FRAME_TICK), 32'h0);
    HRESETn = 1'b1;                       // k = 0

    // First frame after reset is dark, tick marks the first capture.
    dark_frame("frame0");                 // k = 64
    wait_edges(3);                        // k = 67: digit 0 SHOW
    chk("d0_an", 32'(bus.AN), 32'hFE);
    chk("d0_ca", 32'(bus.CA), 32'h40);
    wait_edges(23);                       // k = 90: digit 3 blanking
    chk("d3_blank_an", 32'(bus.AN), 32'hFF);
    wait_edges(1);                        // k = 91: digit 3 SHOW
    chk("d3_an", 32'(bus.AN), 32'hF7);
    chk("d3_ca", 32'(bus.CA), 32'h30);
    chk("d3_dp", 32'(bus.DP), 32'h1);

    // Codes 8..F in frame 2, decimal point on digit 0 only.
    bus.IO_7SEG   = 32'hFEDCBA98;
    bus.IO_7SEGDP = 8'h01;
    wait_edges(40);                       // k = 131
    for (int i = 0; i < 8; i++) begin
      an_e = 8'hFF;
      an_e[i] = 1'b0;
      chk($sformatf("hi%0d_an", i), 32'(bus.AN), 32'(an_e));
      chk($sformatf("hi%0d_ca", i), 32'(bus.CA), 32'(ca_exp[8+i]));
      chk($sformatf("hi%0d_dp", i), 32'(bus.DP), (i == 0) ? 32'h0 : 32'h1);
      if (i == 0) begin
        bus.IO_7SEG   = 32'h76543210;
        bus.IO_7SEGDP = 8'h00;
      end
      wait_edges(8);
    end
    // Codes 0..7 in frame 3; frame 2 above was unaffected by the early change.
    for (int i = 0; i < 8; i++) begin   // k = 195 + 8i
      chk($sformatf("lo%0d_ca", i), 32'(bus.CA), 32'(ca_exp[i]));
      chk($sformatf("lo%0d_dp", i), 32'(bus.DP), 32'h1);
      wait_edges(8);
    end

    // Enables 0x05: only digits 0 and 2 may light (frame 5, k = 321..384).
    bus.IO_7SEGE = 8'h05;                 // k = 259
    wait_edges(62);
    for (int k = 321; k <= 384; k++) begin
      q = k - 1 - 320;
      if ((q % 8) >= 2 && (q / 8) == 0)      an_e = 8'hFE;
      else if ((q % 8) >= 2 && (q / 8) == 2) an_e = 8'hFB;
      else                                   an_e = 8'hFF;
      chk($sformatf("en05_k%0d", k), 32'(bus.AN), 32'(an_e));
      wait_edges(1);
    end

    // Mid-frame input change: old value holds until the next capture.
    bus.IO_7SEGE = 8'hFF;                 // k = 385
    wait_edges(63);                       // k = 448
    chk("tick448", 32'(bus.FRAME_TICK), 32'h1);
    wait_edges(20);                       // k = 468
    bus.IO_7SEG = 32'h89ABCDEF;
    wait_edges(7);                        // k = 475
    chk("old_d3_an", 32'(bus.AN), 32'hF7);
    chk("old_d3_ca", 32'(bus.CA), 32'h30);
    wait_edges(24);                       // k = 499
    chk("old_d6_an", 32'(bus.AN), 32'hBF);
    chk("old_d6_ca", 32'(bus.CA), 32'h02);
    wait_edges(13);                       // k = 512
    chk("tick512", 32'(bus.FRAME_TICK), 32'h1);
    wait_edges(27);                       // k = 539
    chk("new_d3_an", 32'(bus.AN), 32'hF7);
    chk("new_d3_ca", 32'(bus.CA), 32'h46);
    wait_edges(24);                       // k = 563
    chk("new_d6_ca", 32'(bus.CA), 32'h10);

    // One-cycle reset during digit 5 SHOW.
    wait_edges(57);                       // k = 620
    chk("pre_rst_an", 32'(bus.AN), 32'hDF);
    chk("pre_rst_ca", 32'(bus.CA), 32'h08);
    HRESETn = 1'b0;
    wait_edges(1);
    chk_dark("mid_rst");
    chk("mid_rst_tick", 32'(bus.FRAME_TICK), 32'h0);
    HRESETn = 1'b1;                       // k = 0
    dark_frame("post_rst");               // k = 64
    wait_edges(1);                        // k = 65

    // Ten frames of random inputs: one anode at most, blanking between digits, 64-cycle ticks.
    last_an   = 8'hFF;
    ff_run    = 0;
    ticks     = 0;
    last_tick = 0;
    for (int k = 65; k <= 704; k++) begin
      bus.IO_7SEG   = $urandom;
      bus.IO_7SEGE  = 8'($urandom);
      bus.IO_7SEGDP = 8'($urandom);
      chk("an_onehot", 32'($countones(~bus.AN) <= 1), 32'h1);
      if (bus.AN == 8'hFF) begin
        ff_run++;
      end else begin
        chk("blank_gap", 32'(last_an == 8'hFF || bus.AN == last_an || ff_run >= 2), 32'h1);
        last_an = bus.AN;
        ff_run  = 0;
      end
      if (bus.FRAME_TICK === 1'b1) begin
        if (ticks > 0) chk("tick_period", 32'(k - last_tick), 32'd64);
        last_tick = k;
        ticks++;
      end
      wait_edges(1);
    end
    chk("tick_count", 32'(ticks), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
